// File: rtl/alarm_pkg.sv
// Shared encodings, reset constants and BCD step helpers for the alarm-clock controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_T_HR  = 3'd1,
    SET_T_MIN = 3'd2,
    SET_A_HR  = 3'd3,
    SET_A_MIN = 3'd4
  } state_t;

  // Hours are {tens, units} BCD in 5 bits; minutes/seconds are {tens, units} in 7 bits.
  localparam logic [4:0] HR_MIN       = 5'h01;
  localparam logic [4:0] HR_MAX       = 5'h12;
  localparam logic [4:0] RST_TIME_HR  = 5'h12;
  localparam logic [6:0] RST_TIME_MIN = 7'h00;
  localparam logic [4:0] RST_ALM_HR   = 5'h06;
  localparam logic [6:0] RST_ALM_MIN  = 7'h00;

  function automatic logic [4:0] hr_next(input logic [4:0] h);
    if (h == HR_MAX)          hr_next = HR_MIN;
    else if (h[3:0] == 4'd9)  hr_next = 5'h10;
    else                      hr_next = h + 5'd1;
  endfunction

  function automatic logic [6:0] min_next(input logic [6:0] m);
    if (m == 7'h59)           min_next = 7'h00;
    else if (m[3:0] == 4'd9)  min_next = {m[6:4] + 3'd1, 4'd0};
    else                      min_next = m + 7'd1;
  endfunction

endpackage

// File: rtl/alarm_if.sv
// Button/switch inputs and display/alarm outputs of the alarm-clock controller.
interface alarm_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       alarm_en;
  logic       hourten;
  logic [3:0] hour;
  logic [2:0] minten;
  logic [3:0] min;
  logic       blank_hr;
  logic       blank_min;
  logic [2:0] mode;
  logic       alarm_out;

  modport master (
    output btn_mode, btn_inc, alarm_en,
    input  hourten, hour, minten, min, blank_hr, blank_min, mode, alarm_out
  );

  modport slave (
    input  btn_mode, btn_inc, alarm_en,
    output hourten, hour, minten, min, blank_hr, blank_min, mode, alarm_out
  );
endinterface

// File: rtl/hm_bcd_counter.sv
// 12-hour h:mm BCD register; next values are exported so callers can match on the coming time.
module hm_bcd_counter
  import alarm_pkg::*;
#(
  parameter logic [4:0] RST_HR  = 5'h12,
  parameter logic [6:0] RST_MIN = 7'h00
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       carry_in,
  output logic [4:0] hr,
  output logic [6:0] mn,
  output logic [4:0] hr_nx,
  output logic [6:0] mn_nx
);

  // Manual minute increments wrap without touching the hour; only carry_in ripples.
  always_comb begin
    hr_nx = hr;
    mn_nx = mn;
    if (inc_min || carry_in)
      mn_nx = min_next(mn);
    if (inc_hr || (carry_in && mn == 7'h59))
      hr_nx = hr_next(hr);
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      hr <= RST_HR;
      mn <= RST_MIN;
    end else begin
      hr <= hr_nx;
      mn <= mn_nx;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm-clock mode sequencer: timekeeping, set-time/set-alarm editing, blink blanking, alarm ring.
// state     | meaning
// RUN       | time runs, display shows time
// SET_T_HR  | time held at ss=00, btn_inc steps time hour
// SET_T_MIN | time held at ss=00, btn_inc steps time minute
// SET_A_HR  | time runs, display shows alarm, btn_inc steps alarm hour
// SET_A_MIN | time runs, display shows alarm, btn_inc steps alarm minute
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int BLINK_DIV = 25_000_000,
  parameter int ALARM_LEN = 60
) (
  input  logic    CLK100MHZ,
  input  logic    rst,
  alarm_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int RW = $clog2(ALARM_LEN + 1);
  localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);
  localparam logic [RW-1:0] RING_LD  = RW'(ALARM_LEN - 1);

  state_t        state, state_nx;
  logic [PW-1:0] presc;
  logic [6:0]    sec;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic [RW-1:0] ring_cnt;
  logic          alarm_q;
  logic [4:0]    disp_hr;
  logic [6:0]    disp_mn;
  logic          blank_hr_q, blank_min_q;

  logic          press, adv, inc, tick, carry, trig;
  logic          set_t, show_alarm, blank_hr_d, blank_min_d;
  logic          t_inc_hr, t_inc_min, a_inc_hr, a_inc_min;
  logic [4:0]    t_hr, t_hr_nx, a_hr, a_hr_nx;
  logic [6:0]    t_mn, t_mn_nx, a_mn, a_mn_nx;

  // A press while ringing only silences; btn_mode masks a simultaneous btn_inc.
  assign press = bus.btn_mode | bus.btn_inc;
  assign adv   = bus.btn_mode & ~alarm_q;
  assign inc   = bus.btn_inc & ~bus.btn_mode & ~alarm_q;

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (adv) begin
      case (state)
        RUN:       state_nx = SET_T_HR;
        SET_T_HR:  state_nx = SET_T_MIN;
        SET_T_MIN: state_nx = SET_A_HR;
        SET_A_HR:  state_nx = SET_A_MIN;
        default:   state_nx = RUN;
      endcase
    end
  end

  always_comb begin
    set_t       = (state == SET_T_HR) || (state == SET_T_MIN);
    show_alarm  = (state == SET_A_HR) || (state == SET_A_MIN);
    t_inc_hr    = inc && (state == SET_T_HR);
    t_inc_min   = inc && (state == SET_T_MIN);
    a_inc_hr    = inc && (state == SET_A_HR);
    a_inc_min   = inc && (state == SET_A_MIN);
    blank_hr_d  = ((state == SET_T_HR) || (state == SET_A_HR)) && !blink_ph;
    blank_min_d = ((state == SET_T_MIN) || (state == SET_A_MIN)) && !blink_ph;
  end

  assign tick  = !set_t && (presc == PRESC_TC);
  assign carry = tick && (sec == 7'h59);

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      presc <= '0;
      sec   <= 7'h00;
    end else if (set_t) begin
      presc <= '0;
      sec   <= 7'h00;
    end else if (tick) begin
      presc <= '0;
      sec   <= min_next(sec);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  hm_bcd_counter #(.RST_HR(RST_TIME_HR), .RST_MIN(RST_TIME_MIN)) u_time (
    .CLK100MHZ(CLK100MHZ), .rst(rst),
    .inc_hr(t_inc_hr), .inc_min(t_inc_min), .carry_in(carry),
    .hr(t_hr), .mn(t_mn), .hr_nx(t_hr_nx), .mn_nx(t_mn_nx)
  );

  hm_bcd_counter #(.RST_HR(RST_ALM_HR), .RST_MIN(RST_ALM_MIN)) u_alarm (
    .CLK100MHZ(CLK100MHZ), .rst(rst),
    .inc_hr(a_inc_hr), .inc_min(a_inc_min), .carry_in(1'b0),
    .hr(a_hr), .mn(a_mn), .hr_nx(a_hr_nx), .mn_nx(a_mn_nx)
  );

  // Match on the time being entered at this tick so alarm_out rises with the minute change.
  assign trig = carry && bus.alarm_en && (t_hr_nx == a_hr) && (t_mn_nx == a_mn);

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      alarm_q  <= 1'b0;
      ring_cnt <= '0;
    end else if (alarm_q) begin
      if (press || !bus.alarm_en) begin
        alarm_q  <= 1'b0;
        ring_cnt <= '0;
      end else if (tick) begin
        if (ring_cnt == '0) alarm_q <= 1'b0;
        else                ring_cnt <= ring_cnt - RW'(1);
      end
    end else if (trig && !press) begin
      alarm_q  <= 1'b1;
      ring_cnt <= RING_LD;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (press) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (blink_cnt == BLINK_TC) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      disp_hr     <= RST_TIME_HR;
      disp_mn     <= RST_TIME_MIN;
      blank_hr_q  <= 1'b0;
      blank_min_q <= 1'b0;
    end else begin
      disp_hr     <= show_alarm ? a_hr : t_hr;
      disp_mn     <= show_alarm ? a_mn : t_mn;
      blank_hr_q  <= blank_hr_d;
      blank_min_q <= blank_min_d;
    end
  end

  assign bus.hourten   = disp_hr[4];
  assign bus.hour      = disp_hr[3:0];
  assign bus.minten    = disp_mn[6:4];
  assign bus.min       = disp_mn[3:0];
  assign bus.blank_hr  = blank_hr_q;
  assign bus.blank_min = blank_min_q;
  assign bus.mode      = state;
  assign bus.alarm_out = alarm_q;

endmodule
